// File: rtl/gbp_index_queue.sv
// In-order queue of global-predictor indices between fetch and execute resolution.
// Optional GBP_INDEX_QUEUE_PC_CHECK_EN: stores the PC and treats a pop with a PC mismatch as a flush.
module gbp_index_queue #(
  parameter int unsigned VLEN                     = 64,
  parameter int unsigned GlobalPredictorIndexBits = 8,
  parameter int unsigned NR_ENTRIES               = 8,
  localparam int unsigned PTR_W = $clog2(NR_ENTRIES),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic                                debug_mode_i,
  input  logic                                push_valid_i,
  output logic                                push_ready_o,
  input  logic [GlobalPredictorIndexBits-1:0] push_index_i,
  input  logic [VLEN-1:0]                     push_pc_i,
  input  logic                                resolve_valid_i,
  input  logic [VLEN-1:0]                     resolve_pc_i,
  input  logic                                resolve_taken_i,
  output logic                                update_valid_o,
  output logic [VLEN-1:0]                     update_pc_o,
  output logic                                update_taken_o,
  output logic [GlobalPredictorIndexBits-1:0] update_index_o,
  output logic [CNT_W-1:0]                    count_o,
  output logic                                orphan_o
);

  typedef struct packed {
    logic [GlobalPredictorIndexBits-1:0] idx;
`ifdef GBP_INDEX_QUEUE_PC_CHECK_EN
    logic [VLEN-1:0]                     pc;
`endif
  } entry_t;

  entry_t             mem_q [NR_ENTRIES];
  entry_t             wr_entry, head;
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               push_en, pop_req, pop_en, mismatch, kill, orphan_d, upd_valid_d;

  assign push_ready_o = (count_q < CNT_W'(NR_ENTRIES));
  assign head         = mem_q[rptr_q];

  always_comb begin
    wr_entry     = '0;
    wr_entry.idx = push_index_i;
`ifdef GBP_INDEX_QUEUE_PC_CHECK_EN
    wr_entry.pc  = push_pc_i;
`endif
  end

  assign pop_req = resolve_valid_i && (count_q != '0) && !flush_i;
`ifdef GBP_INDEX_QUEUE_PC_CHECK_EN
  assign mismatch = pop_req && (head.pc != resolve_pc_i);
`else
  assign mismatch = 1'b0;
`endif
  // A PC mismatch means the queue lost sync with execute; drop everything like a flush.
  assign kill        = flush_i || mismatch;
  assign pop_en      = pop_req && !mismatch;
  assign push_en     = push_valid_i && push_ready_o && !kill;
  assign orphan_d    = !flush_i && resolve_valid_i && ((count_q == '0) || mismatch);
  assign upd_valid_d = pop_en && !debug_mode_i;

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wptr_q] <= wr_entry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (kill) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + PTR_W'(1);
      if (pop_en)  rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  // Data outputs hold between pops; only the strobe and orphan pulse return to 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      update_valid_o <= 1'b0;
      update_pc_o    <= '0;
      update_taken_o <= 1'b0;
      update_index_o <= '0;
      orphan_o       <= 1'b0;
    end else begin
      update_valid_o <= upd_valid_d;
      orphan_o       <= orphan_d;
      if (pop_en) begin
        update_pc_o    <= resolve_pc_i;
        update_taken_o <= resolve_taken_i;
        update_index_o <= head.idx;
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_gbp_index_queue.sv
// Randomized self-checking bench for gbp_index_queue against a queue-based reference model.
module tb_gbp_index_queue;
  localparam int IW = 8;
  localparam int VL = 64;
  localparam int N  = 8;
  localparam int CW = $clog2(N) + 1;

  logic          clk_i = 1'b0, rst_ni = 1'b0;
  logic          flush_i = 0, debug_mode_i = 0, push_valid_i = 0, resolve_valid_i = 0, resolve_taken_i = 0;
  logic [IW-1:0] push_index_i = '0;
  logic [VL-1:0] push_pc_i = '0, resolve_pc_i = '0;
  logic          push_ready_o, update_valid_o, update_taken_o, orphan_o;
  logic [VL-1:0] update_pc_o;
  logic [IW-1:0] update_index_o;
  logic [CW-1:0] count_o;

  gbp_index_queue #(.VLEN(VL), .GlobalPredictorIndexBits(IW), .NR_ENTRIES(N)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o), .push_index_i(push_index_i),
    .push_pc_i(push_pc_i), .resolve_valid_i(resolve_valid_i), .resolve_pc_i(resolve_pc_i),
    .resolve_taken_i(resolve_taken_i), .update_valid_o(update_valid_o), .update_pc_o(update_pc_o),
    .update_taken_o(update_taken_o), .update_index_o(update_index_o), .count_o(count_o),
    .orphan_o(orphan_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [IW-1:0] idx; logic [VL-1:0] pc; } ent_t;
  ent_t          q[$];
  logic          m_uv, m_ut, m_orph;
  logic [VL-1:0] m_upc;
  logic [IW-1:0] m_uidx;
  int            checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_uv = 0; m_ut = 0; m_orph = 0; m_upc = '0; m_uidx = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 64'(count_o), 64'(q.size()));
    chk({tag, ".ready"}, 64'(push_ready_o), 64'(q.size() < N));
    chk({tag, ".uvalid"}, 64'(update_valid_o), 64'(m_uv));
    chk({tag, ".orphan"}, 64'(orphan_o), 64'(m_orph));
    chk({tag, ".uidx"}, 64'(update_index_o), 64'(m_uidx));
    chk({tag, ".upc"}, update_pc_o, m_upc);
    chk({tag, ".utaken"}, 64'(update_taken_o), 64'(m_ut));
  endtask

  // One clock of stimulus; model advances at the edge, outputs checked 1 time unit later.
  task automatic step(input string tag, input logic pv, input logic [IW-1:0] pidx, input logic [VL-1:0] ppc,
                      input logic rv, input logic [VL-1:0] rpc, input logic rt,
                      input logic fl = 0, input logic dbg = 0);
    logic can_push;
    @(negedge clk_i);
    push_valid_i = pv; push_index_i = pidx; push_pc_i = ppc;
    resolve_valid_i = rv; resolve_pc_i = rpc; resolve_taken_i = rt;
    flush_i = fl; debug_mode_i = dbg;
    @(posedge clk_i);
    can_push = pv && (q.size() < N);
    m_uv = 0; m_orph = 0;
    if (fl) begin
      q.delete();
    end else begin
      if (rv && q.size() == 0) begin
        m_orph = 1;
      end else if (rv) begin
`ifdef GBP_INDEX_QUEUE_PC_CHECK_EN
        if (q[0].pc != rpc) begin
          q.delete(); m_orph = 1; can_push = 0;
        end else
`endif
        begin
          m_uidx = q[0].idx; m_upc = rpc; m_ut = rt; m_uv = !dbg;
          void'(q.pop_front());
        end
      end
      if (can_push) q.push_back('{pidx, ppc});
    end
    #1;
    check_all(tag);
  endtask

  function automatic logic [VL-1:0] head_pc();
    if (q.size() != 0 && $urandom_range(7) != 0) return q[0].pc;
    return VL'($urandom);
  endfunction

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk_i); rst_ni = 1;
    step("idle0", 0, 0, 0, 0, 0, 0);
    step("idle1", 0, 0, 0, 0, 0, 0);

    step("push11", 1, 8'h11, 'h1000, 0, 0, 0);
    step("push22", 1, 8'h22, 'h1004, 0, 0, 0);
    step("push33", 1, 8'h33, 'h1008, 0, 0, 0);
    step("res1000", 0, 0, 0, 1, 'h1000, 1);
    step("res1004", 0, 0, 0, 1, 'h1004, 0);
    step("res1008", 0, 0, 0, 1, 'h1008, 1);

    for (int i = 0; i < N; i++) step("fill", 1, IW'(8'h80 + i), VL'('h3000 + 4*i), 0, 0, 0);
    step("full_push_pop", 1, 8'hEE, 'h9999, 1, 'h3000, 1);
    for (int i = 0; i < 20; i++)
      step("mixed", 1'($urandom), IW'($urandom), VL'($urandom), 1'($urandom), head_pc(), 1'($urandom));

    for (int i = 0; i < 12 && q.size() != 0; i++) step("drain", 0, 0, 0, 1, q[0].pc, 0);
    step("orphan_push44", 1, 8'h44, 'h4000, 1, 'h1234, 1);
    step("orphan_clear", 1, 8'h45, 'h4004, 0, 0, 0);
    step("push46", 1, 8'h46, 'h4008, 0, 0, 0);
    step("flush", 1, 8'h47, 'h400C, 1, 'h4000, 1, 1);
    step("post_flush", 0, 0, 0, 0, 0, 0);
    step("push55", 1, 8'h55, 'h5000, 0, 0, 0);
    step("res55", 0, 0, 0, 1, 'h5000, 1);

    step("push66", 1, 8'h66, 'h6000, 0, 0, 0);
    step("push67", 1, 8'h67, 'h6004, 0, 0, 0);
    step("dbg_res66", 0, 0, 0, 1, 'h6000, 1, 0, 1);
    step("res67", 0, 0, 0, 1, 'h6004, 0);
    step("push2000", 1, 8'h77, 'h2000, 0, 0, 0);
    step("res2004", 0, 0, 0, 1, 'h2004, 1);
    step("after2004", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 5; i++) step("prefill", 1, IW'($urandom), VL'($urandom), 0, 0, 0);
    step("pop_before_rst", 0, 0, 0, 1, q[0].pc, 1);
    @(negedge clk_i); #2;
    rst_ni = 0; #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk_i); rst_ni = 1;
    step("post_rst", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(3) != 0), IW'($urandom), VL'($urandom), 1'($urandom), head_pc(),
           1'($urandom), 1'($urandom_range(31) == 0), 1'($urandom_range(7) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
